// File: rtl/seq_divider_pkg.sv
// Shared constants, op encoding, FSM state type and magnitude helper for seq_divider.
package seq_divider_pkg;
  localparam int XLEN        = 32;
  localparam int DIV_ITER    = 32;
  localparam int DIV_LATENCY = 34;
  localparam int OP_DIV_BASE = 17;

  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Unsigned magnitude; 0x80000000 maps onto itself, which is its correct magnitude.
  function automatic logic [XLEN-1:0] div_mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign application and quotient/remainder select for seq_divider.
module div_sign_fix
  import seq_divider_pkg::*;
(
  input  logic [XLEN-1:0] quo_mag_i,
  input  logic [XLEN-1:0] rem_mag_i,
  input  logic            q_neg_i,
  input  logic            r_neg_i,
  input  logic            sel_rem_i,
  output logic [XLEN-1:0] result_o
);
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  assign quo      = q_neg_i ? -quo_mag_i : quo_mag_i;
  assign rem      = r_neg_i ? -rem_mag_i : rem_mag_i;
  assign result_o = sel_rem_i ? rem : quo;
endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 DIV/DIVU/REM/REMU: done 34 cycles after start, 2 for divide-by-zero/overflow.
// SEQ_DIVIDER_RESULT_CACHE_EN: reuse the last operands' quotient/remainder with done 1 cycle after start.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  div_state_e      state_q, state_d;
  logic            accept, finish, hit, special, div_zero, ovf, sgn_in, ge;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d, fix_res, hit_res, rem_sub;
  logic [XLEN:0]   rem_shift;
  logic            sel_rem_q, sel_rem_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic            done_q, done_d;

  assign sgn_in   = ~op[0];
  assign div_zero = (divisor == '0);
  assign ovf      = sgn_in && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
  assign special  = div_zero | ovf;

  div_sign_fix u_fix (
    .quo_mag_i (quo_q),
    .rem_mag_i (rem_q),
    .q_neg_i   (q_neg_q),
    .r_neg_i   (r_neg_q),
    .sel_rem_i (sel_rem_q),
    .result_o  (fix_res)
  );

`ifdef SEQ_DIVIDER_RESULT_CACHE_EN
  logic            c_vld_q, c_uns_q, uns_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_quo_q, c_rem_q, a_raw_q, b_raw_q, fix_alt;

  // Second select gives the result the op did not ask for, so both are cached.
  div_sign_fix u_fix_alt (
    .quo_mag_i (quo_q),
    .rem_mag_i (rem_q),
    .q_neg_i   (q_neg_q),
    .r_neg_i   (r_neg_q),
    .sel_rem_i (~sel_rem_q),
    .result_o  (fix_alt)
  );

  assign hit     = c_vld_q && (dividend == c_a_q) && (divisor == c_b_q) && (op[0] == c_uns_q);
  assign hit_res = op[1] ? c_rem_q : c_quo_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_vld_q <= 1'b0;
      c_uns_q <= 1'b0;
      uns_q   <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
      a_raw_q <= '0;
      b_raw_q <= '0;
    end else begin
      if (accept) begin
        a_raw_q <= dividend;
        b_raw_q <= divisor;
        uns_q   <= op[0];
      end
      if (kill) begin
        c_vld_q <= 1'b0;
      end else if (finish) begin
        c_vld_q <= 1'b1;
        c_a_q   <= a_raw_q;
        c_b_q   <= b_raw_q;
        c_uns_q <= uns_q;
        c_quo_q <= sel_rem_q ? fix_alt : fix_res;
        c_rem_q <= sel_rem_q ? fix_res : fix_alt;
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && !hit) state_d = special ? FIX : CALC;
        CALC:    if (cnt_q == 5'(DIV_ITER - 1)) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = 1'b0;
    accept = 1'b0;
    finish = 1'b0;
    case (state_q)
      IDLE:    accept = start & ~kill;
      CALC:    busy   = 1'b1;
      FIX: begin
        busy   = 1'b1;
        finish = ~kill;
      end
      default: busy = 1'b0;
    endcase
  end

  // Restoring step: 33-bit partial remainder compared against the divisor magnitude.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign ge        = (rem_shift >= {1'b0, dvs_q});
  assign rem_sub   = rem_shift[XLEN-1:0] - dvs_q;

  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    sel_rem_d = sel_rem_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    done_d    = 1'b0;
    result_d  = result_q;
    if (accept) begin
      cnt_d     = '0;
      sel_rem_d = op[1];
      q_neg_d   = sgn_in & (dividend[XLEN-1] ^ divisor[XLEN-1]) & ~div_zero;
      r_neg_d   = sgn_in & dividend[XLEN-1];
      dvs_d     = div_mag(divisor, sgn_in);
      if (div_zero) begin
        quo_d = '1;
        rem_d = div_mag(dividend, sgn_in);
      end else if (ovf) begin
        quo_d = {1'b1, {(XLEN-1){1'b0}}};
        rem_d = '0;
      end else begin
        quo_d = div_mag(dividend, sgn_in);
        rem_d = '0;
      end
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 5'd1;
      quo_d = {quo_q[XLEN-2:0], ge};
      rem_d = ge ? rem_sub : rem_shift[XLEN-1:0];
    end
    if (finish) begin
      done_d   = 1'b1;
      result_d = fix_res;
    end else if (accept && hit) begin
      done_d   = 1'b1;
      result_d = hit_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      sel_rem_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      sel_rem_q <= sel_rem_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t sbq[$];

  // Model of the optional result cache and of the last delivered result.
  logic        m_vld = 1'b0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic        m_uns = 1'b0;
  logic [31:0] last_res = 32'd0;

  seq_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (o[0]) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
    return o[1] ? r : q;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%08h, expected no done (cycle %0d)", result, cyc);
      end else begin
        e = sbq.pop_front();
        check("result", result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called just after a posedge with the DUT idle; returns in the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    bit   hit;
    int   lat, bc;
    exp_t e;
    hit = 1'b0;
`ifdef SEQ_DIVIDER_RESULT_CACHE_EN
    hit = m_vld && (a == m_a) && (b == m_b) && (o[0] == m_uns);
`endif
    if (hit) lat = 1;
    else if (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 2;
    else lat = 34;
    op = o; dividend = a; divisor = b; start = 1'b1;
    e.res = ref_result(o, a, b);
    e.due = cyc + lat;
    sbq.push_back(e);
    last_res = e.res;
    m_vld = 1'b1; m_a = a; m_b = b; m_uns = o[0];
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0; dividend = $urandom; divisor = $urandom; op = 2'($urandom_range(0, 3));
    end
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (!hold) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("busy_cycles", 32'(bc), 32'(lat - 1));
    if (!hold) start = 1'b0;
  endtask

  task automatic kill_test();
    int c0;
    op = 2'd1; dividend = 32'd1000; divisor = 32'd3; start = 1'b1; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < c0 + 10) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    m_vld = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_result", result, last_res);
    op = 2'd1; dividend = 32'd9; divisor = 32'd3; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("kill_result_hold", result, last_res);
  endtask

  task automatic reset_test();
    int c0;
    op = 2'd2; dividend = 32'h1234_5678 + 32'(cyc); divisor = 32'($urandom_range(1, 1000));
    start = 1'b1; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < c0 + 20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;
    m_vld = 1'b0;
    last_res = 32'd0;
  endtask

  task automatic rand_operands(output logic [31:0] a, output logic [31:0] b);
    case ($urandom_range(0, 3))
      0: a = 32'h8000_0000;
      1: a = 32'($urandom_range(0, 200));
      default: a = $urandom;
    endcase
    case ($urandom_range(0, 5))
      0: b = 32'd0;
      1: b = 32'hFFFF_FFFF;
      2: b = 32'($urandom_range(1, 20));
      3: b = -32'($urandom_range(1, 20));
      default: b = $urandom;
    endcase
  endtask

  initial begin
    logic [31:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;

    run_op(2'd1, 32'd100, 32'd7, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd1, 32'd5, 32'd0, 1'b0);
    run_op(2'd3, 32'd5, 32'd0, 1'b0);
    kill_test();
    run_op(2'd1, 32'd9, 32'd3, 1'b0);
    run_op(2'd0, 32'd100, 32'hFFFF_FFF9, 1'b0);
    run_op(2'd2, 32'd100, 32'hFFFF_FFF9, 1'b0);
    run_op(2'd1, 32'd100, 32'hFFFF_FFF9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rand_operands(ra, rb);
      run_op(2'($urandom_range(0, 3)), ra, rb, 1'b1);
    end
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rand_operands(ra, rb);
      if (i % 5 == 4) run_op(op ^ 2'd2, m_a, m_b, 1'b0);
      else run_op(2'($urandom_range(0, 3)), ra, rb, 1'b0);
    end

    reset_test();
    run_op(2'd1, 32'd9, 32'd3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
